// File: rtl/aes128_top.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly.
// Inputs are sampled only while idle; the ciphertext is announced with a one-cycle valid strobe.
module aes128_top (
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);

    typedef enum logic {IDLE, RUN} state_e;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_e       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] key_q, key_d;
    logic [127:0] dout_q, dout_d;
    logic         valid_q, valid_d;

    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] sr_blk, mix_blk, next_key, round_out;
    logic [31:0]  w0, w1, w2, w3, sub_rot;

    // Byte i sits at bits [127-8i -: 8]; row i%4, column i/4.
    always_comb begin
        sr_blk  = '0;
        mix_blk = '0;
        for (int i = 0; i < 16; i++) sb[i] = sbox(blk_q[127-8*i -: 8]);
        for (int i = 0; i < 16; i++) begin
            sr[i] = sb[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
            sr_blk[127-8*i -: 8] = sr[i];
        end
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mix_blk[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mix_blk[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mix_blk[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mix_blk[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    end

    always_comb begin
        sub_rot  = {sbox(key_q[23:16]), sbox(key_q[15:8]), sbox(key_q[7:0]), sbox(key_q[31:24])};
        w0       = key_q[127:96] ^ sub_rot ^ {rcon(round_q), 24'h000000};
        w1       = key_q[95:64] ^ w0;
        w2       = key_q[63:32] ^ w1;
        w3       = key_q[31:0] ^ w2;
        next_key = {w0, w1, w2, w3};
        round_out = ((round_q == 4'd10) ? sr_blk : mix_blk) ^ next_key;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        blk_d   = blk_q;
        key_d   = key_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (AES_en) begin
                    blk_d   = AES_data_in ^ AES_key_in;
                    key_d   = AES_key_in;
                    round_d = 4'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                blk_d = round_out;
                key_d = next_key;
                if (round_q == 4'd10) begin
                    dout_d  = round_out;
                    valid_d = 1'b1;
                    round_d = 4'd0;
                    state_d = IDLE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            blk_q   <= '0;
            key_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign AES_data_out       = dout_q;
    assign AES_data_out_valid = valid_q;

endmodule

// File: tb/tb_aes128_top.sv
// Scoreboard bench for aes128_top: stimulus pushes expected ciphertext and completion cycle,
// a negedge monitor pops and compares on every valid strobe.
module tb_aes128_top;

    logic         clk;
    logic         rst;
    logic         en;
    logic [127:0] din;
    logic [127:0] kin;
    logic [127:0] dout;
    logic         dvalid;

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_top dut (
        .AES_clk            (clk),
        .AES_rst            (rst),
        .AES_en             (en),
        .AES_data_in        (din),
        .AES_key_in         (kin),
        .AES_data_out       (dout),
        .AES_data_out_valid (dvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: each valid strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (dvalid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("ciphertext", dout, e.data);
                check("completion_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    // Advance to just after the n-th following rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse AES_en for one edge; the start edge is the next one, completion 10 edges later.
    task automatic start_pulse(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct);
        exp_t e;
        din = pt;
        kin = key;
        en  = 1'b1;
        e.data = ct;
        e.cyc  = cyc + 11;
        q.push_back(e);
        tick(1);
        en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d results outstanding expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        en  = 1'b0;
        din = '0;
        kin = '0;

        // Reset held for three cycles.
        tick(3);
        check("reset_data_out", dout, 128'h0);
        check("reset_valid", 128'(dvalid), 128'h0);
        rst = 1'b0;
        tick(2);

        // FIPS-197 App. B, one-cycle start pulse, then output hold after the strobe.
        start_pulse(PT_B, KEY_B, CT_B);
        drain(20);
        tick(5);
        check("hold_after_B", dout, CT_B);
        check("valid_low_after_B", 128'(dvalid), 128'h0);

        // FIPS-197 App. C.1.
        start_pulse(PT_C, KEY_C, CT_C);
        drain(20);
        tick(3);

        // All-zero key/plaintext with AES_en held high for 50 cycles: starts every 11 edges.
        din = '0;
        kin = '0;
        en  = 1'b1;
        for (int j = 0; j < 5; j++) begin
            e.data = CT_Z;
            e.cyc  = cyc + 11 + 11 * j;
            q.push_back(e);
        end
        tick(50);
        en = 1'b0;
        drain(30);
        tick(3);

        // Inputs and AES_en disturbed during RUN must not affect the result.
        start_pulse(PT_B, KEY_B, CT_B);
        for (int i = 1; i <= 8; i++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            kin = {$urandom, $urandom, $urandom, $urandom};
            en  = 1'($urandom_range(0, 1));
            tick(1);
        end
        en = 1'b0;
        drain(20);
        tick(4);
        check("hold_after_disturbed", dout, CT_B);

        // Back-to-back: App. B then App. C.1 with AES_en held, inputs switched during the first run.
        din = PT_B;
        kin = KEY_B;
        en  = 1'b1;
        e.data = CT_B;
        e.cyc  = cyc + 11;
        q.push_back(e);
        e.data = CT_C;
        e.cyc  = cyc + 22;
        q.push_back(e);
        tick(1);
        din = PT_C;
        kin = KEY_C;
        tick(11);
        en = 1'b0;
        drain(20);
        tick(3);

        // Reset in the middle of a round: outputs clear at once and no strobe follows.
        din = PT_B;
        kin = KEY_B;
        en  = 1'b1;
        tick(1);
        en = 1'b0;
        tick(4);
        rst = 1'b1;
        #1;
        check("midrun_reset_data_out", dout, 128'h0);
        check("midrun_reset_valid", 128'(dvalid), 128'h0);
        tick(2);
        rst = 1'b0;
        tick(15);
        check("no_result_after_abort", dout, 128'h0);

        // A fresh start after the abort completes with normal latency.
        start_pulse(PT_C, KEY_C, CT_C);
        drain(20);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes128_top.md
Name: aes128_top

Overview:
- Iterative AES-128 encryption core (FIPS-197, encrypt only). It is the top level of the AES block.
- Computes one round per clock and expands the key on the fly, so no round-key storage is needed.
- Accepts a 128-bit plaintext and key on a start request. Emits the ciphertext with a one-cycle valid strobe.

Parameters:
- none (AES-128 fixed: 10 rounds, 128-bit key)

Ports:
- AES_clk  input  1  rising-edge clock
- AES_rst  input  1  asynchronous, active-high reset
- AES_en  input  1  start request, level sensitive, sampled only while idle
- AES_data_in  input  128  plaintext; bits [127:120] = byte 0 (FIPS-197 input byte order)
- AES_key_in  input  128  cipher key, same byte order
- AES_data_out  output  128  ciphertext, same byte order; holds last result
- AES_data_out_valid  output  1  one-cycle pulse when AES_data_out updates

Behaviour:
- Reset (async, AES_rst=1):
  - state=IDLE, round counter=0, internal state/key regs=0
  - AES_data_out=0, AES_data_out_valid=0
- State is column-major: byte i is at row i%4, column i/4.
- IDLE:
  - If AES_en=1 at a rising edge, register state=AES_data_in XOR AES_key_in (initial AddRoundKey).
  - Same edge: key reg=AES_key_in, round=1, go to RUN.
  - If AES_en=0, stay in IDLE; valid=0.
- RUN, each edge for round r=1..10:
  - state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), K_r). Round 10 omits MixColumns.
  - K_r is derived combinationally from K_{r-1} (key reg):
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon[r]
    - w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'
    - key reg <= K_r
    - Rcon = 01,02,04,08,10,20,40,80,1b,36 in the MSB byte
- At the round-10 edge:
  - AES_data_out <= final state, AES_data_out_valid <= 1 for exactly one cycle
  - return to IDLE, round=0
- Latency: start edge S; valid high in the cycle after edge S+10 (11 edges after start). Throughput is one block per 11 cycles.
- AES_en held high continuously:
  - a new encryption starts on the first IDLE edge, i.e. the edge after the valid pulse begins
  - it re-samples the inputs at that edge
  - results are produced back-to-back every 11 cycles
- Inputs (AES_data_in, AES_key_in, AES_en) are ignored during RUN. Deasserting AES_en mid-operation does not abort; the block completes and reports.
- AES_data_out keeps its value after valid drops, until the next completion or reset.
- Reset asserted mid-operation: immediate return to reset values; no valid pulse for the aborted block.
- S-box: 256-entry combinational lookup function. 20 instances: 16 for the state, 4 for the key schedule.
- MixColumns uses xtime: (b<<1) ^ (b[7] ? 8'h1b : 0).

Test Plan:
- Reset check: hold AES_rst=1 for 3 cycles -> AES_data_out=0, valid=0. Assert reset mid-round -> outputs return to 0 and no valid pulse follows.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, AES_en pulsed 1 cycle -> valid exactly 11 edges later, out=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out=69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero key and pt -> out=66e94bd4ef8a2c3b884cfa59ca342b2e. AES_en held high for 500 ns -> repeated valid pulses every 11 cycles with the same result.
- Input change during RUN: start with App. B vectors, then change AES_data_in/AES_key_in and drop AES_en on cycles 2..8 -> result still 3925841d…0b32. Output holds after valid drops.
- Back-to-back: App. B then App. C.1 with AES_en held high and inputs switched during the first run -> first result App. B, second App. C.1, valid pulses 11 cycles apart.
